// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Contents : FSM state encodings, opcode constants, ALU/mux select encodings
//            and control-word type shared by the multicycle controller and
//            the ALU control decoder.
// Revision : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

    // States whose exit to FETCH marks a completed instruction.
    function automatic logic is_terminal(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RTYPEWB) ||
               (s == S_ADDIWB) || (s == S_BEQEX) || (s == S_JEX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_outdec
// Contents : Moore output decoder mapping controller state to control word.
// Revision : 1.0  initial release
// ============================================================================
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JEX: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Contents : Multicycle MIPS main controller: state register, next-state
//            logic and retired-instruction counter.
// Revision : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             zero,
    output logic             iord,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    state_t           state;
    state_t           next_state;
    ctrl_t            ctrl;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = S_MEMWB;
            S_RTYPEEX: next_state = S_RTYPEWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    // An illegal-op bounce out of DECODE is not a completion, so only
    // terminal states qualify.
    assign retire = is_terminal(state) && (next_state == S_FETCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    mips_ctrl_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    assign iord       = ctrl.iord;
    assign ir_write   = ctrl.ir_write;
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign alu_op     = ctrl.alu_op;
    assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
    assign illegal_op = (state == S_DECODE) && !op_supported(op);
    assign retired    = retired_cnt;
    assign state_dbg  = state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Contents : Directed self-checking bench for the multicycle MIPS controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [5:0]       op;
    logic             zero;
    logic             iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]       alu_src_b, pc_src, alu_op;
    logic             pc_en, illegal_op;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .iord       (iord),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .pc_en      (pc_en),
        .illegal_op (illegal_op),
        .retired    (retired),
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'b100011;
        zero  = 1'b0;
        #3;
        chk("rst_state",    32'(state_dbg), 32'd0);
        chk("rst_retired",  32'(retired),   32'd0);
        chk("rst_ir_write", 32'(ir_write),  32'd1);
        chk("rst_pc_en",    32'(pc_en),     32'd1);
        chk("rst_srcb",     32'(alu_src_b), 32'd1);
        tick();
        reset = 1'b0;

        // LW: 0,1,2,3,4,0
        chk("lw_c1_state", 32'(state_dbg), 32'd0);
        chk("lw_c1_regw",  32'(reg_write), 32'd0);
        tick();
        chk("lw_c2_state", 32'(state_dbg), 32'd1);
        chk("lw_c2_srcb",  32'(alu_src_b), 32'd3);
        chk("lw_c2_ill",   32'(illegal_op), 32'd0);
        tick();
        chk("lw_c3_state", 32'(state_dbg), 32'd2);
        chk("lw_c3_srca",  32'(alu_src_a), 32'd1);
        chk("lw_c3_srcb",  32'(alu_src_b), 32'd2);
        tick();
        chk("lw_c4_state", 32'(state_dbg), 32'd3);
        chk("lw_c4_iord",  32'(iord),      32'd1);
        chk("lw_c4_regw",  32'(reg_write), 32'd0);
        tick();
        chk("lw_c5_state", 32'(state_dbg),  32'd4);
        chk("lw_c5_regw",  32'(reg_write),  32'd1);
        chk("lw_c5_m2r",   32'(mem_to_reg), 32'd1);
        chk("lw_c5_ret",   32'(retired),    32'd0);
        tick();
        chk("lw_end_state", 32'(state_dbg), 32'd0);
        chk("lw_end_regw",  32'(reg_write), 32'd0);
        chk("lw_end_ret",   32'(retired),   32'd1);

        // BEQ taken
        op = 6'b000100; zero = 1'b1;
        tick();
        tick();
        chk("beq1_state", 32'(state_dbg), 32'd8);
        chk("beq1_pc_en", 32'(pc_en),     32'd1);
        chk("beq1_pcsrc", 32'(pc_src),    32'd1);
        chk("beq1_aluop", 32'(alu_op),    32'd1);
        tick();
        chk("beq1_ret",   32'(retired),   32'd2);
        // BEQ not taken
        zero = 1'b0;
        tick();
        tick();
        chk("beq0_state", 32'(state_dbg), 32'd8);
        chk("beq0_pc_en", 32'(pc_en),     32'd0);
        tick();
        chk("beq0_ret",   32'(retired),   32'd3);

        // RTYPE then ADDI, back to back
        op = 6'b000000;
        tick();
        tick();
        chk("rt_state", 32'(state_dbg), 32'd6);
        chk("rt_aluop", 32'(alu_op),    32'd2);
        tick();
        chk("rtwb_state", 32'(state_dbg), 32'd7);
        chk("rtwb_regdst", 32'(reg_dst),  32'd1);
        chk("rtwb_regw",  32'(reg_write), 32'd1);
        tick();
        chk("rt_ret", 32'(retired), 32'd4);
        op = 6'b001000;
        tick();
        tick();
        chk("addi_state", 32'(state_dbg), 32'd9);
        chk("addi_aluop", 32'(alu_op),    32'd0);
        chk("addi_srcb",  32'(alu_src_b), 32'd2);
        tick();
        chk("addiwb_state", 32'(state_dbg), 32'd10);
        chk("addiwb_regdst", 32'(reg_dst),  32'd0);
        tick();
        chk("addi_end_state", 32'(state_dbg), 32'd0);
        chk("addi_ret",       32'(retired),   32'd5);

        // Illegal opcode
        op = 6'b111111;
        tick();
        chk("ill_state", 32'(state_dbg),  32'd1);
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        tick();
        chk("ill_back",  32'(state_dbg),  32'd0);
        chk("ill_clear", 32'(illegal_op), 32'd0);
        chk("ill_ret",   32'(retired),    32'd5);

        // SW
        op = 6'b101011;
        tick();
        tick();
        tick();
        chk("sw_state", 32'(state_dbg), 32'd5);
        chk("sw_memw",  32'(mem_write), 32'd1);
        chk("sw_iord",  32'(iord),      32'd1);
        tick();
        chk("sw_ret",   32'(retired),   32'd6);

        // Reset in the middle of MEMRD, between edges
        op = 6'b100011;
        tick();
        tick();
        tick();
        chk("mr_state", 32'(state_dbg), 32'd3);
        reset = 1'b1;
        #1;
        chk("mr_rst_state", 32'(state_dbg), 32'd0);
        chk("mr_rst_ret",   32'(retired),   32'd0);
        chk("mr_rst_pc_en", 32'(pc_en),     32'd1);
        tick();
        reset = 1'b0;
        chk("mr_hold_state", 32'(state_dbg), 32'd0);
        chk("mr_hold_ret",   32'(retired),   32'd0);

        // J repeated until the counter reaches all-ones, then one more wraps it
        op = 6'b000010;
        for (int i = 0; i < 15; i++) begin
            tick();
            tick();
            tick();
        end
        chk("j_full_ret", 32'(retired), 32'd15);
        tick();
        tick();
        chk("j_state", 32'(state_dbg), 32'd11);
        chk("j_pcsrc", 32'(pc_src),    32'd2);
        chk("j_pc_en", 32'(pc_en),     32'd1);
        tick();
        chk("j_wrap_state", 32'(state_dbg), 32'd0);
        chk("j_wrap_ret",   32'(retired),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
